// File: rtl/tile_instr_sequencer.sv
// Per-tile instruction store and issue sequencer: host loads a short program,
// then the block streams it into the CGRA tile one word per clock.
module tile_instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IW    = 64,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          loop_en,
  input  logic          stop,
  input  logic          stall,
  input  logic          clear_req,
  output logic [IW-1:0] instruction,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] issue_count
);

  localparam logic [IW-1:0] NOP = IW'(64'h0000_0000_0000_0007);
  localparam logic [IW-1:0] CLR = IW'(64'h2000_0000_0000_0007);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_mem [DEPTH];
  logic [IW-1:0] r_instr;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_nxt;
  logic [AW:0]   r_len;
  logic          r_loop;
  logic          r_done;
  logic          r_err;
  logic [CW-1:0] r_cnt;

  logic w_len_ok, w_last, w_issue, w_accept, w_reject, w_clear;

  assign w_len_ok = (prog_len != '0) && (prog_len <= (AW+1)'(DEPTH));
  assign w_last   = ({1'b0, r_nxt} == (r_len - 1'b1));

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clear_req) begin
          w_clear = 1'b1;
        end else if (start) begin
          if (w_len_ok) begin
            w_accept    = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_RUN, S_HOLD: begin
        // stop outranks stall; the pending entry is simply never issued
        if (stop) begin
          w_state_nxt = S_DONE;
        end else if (stall) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_issue     = 1'b1;
          w_state_nxt = (w_last && !r_loop) ? S_DONE : S_RUN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_instr <= NOP;
      r_pc    <= '0;
      r_nxt   <= '0;
      r_len   <= '0;
      r_loop  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_instr <= w_issue ? r_mem[r_nxt] : (w_clear ? CLR : NOP);
      r_pc    <= w_issue ? r_nxt : '0;
      r_done  <= (r_state == S_DONE);
      r_err   <= w_reject;
      if (w_accept) begin
        r_len  <= prog_len;
        r_loop <= loop_en;
        r_nxt  <= '0;
        r_cnt  <= '0;
      end else if (w_issue) begin
        r_nxt <= w_last ? '0 : r_nxt + 1'b1;
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Program store is not reset so a tile reset keeps the loaded program.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && load_en) r_mem[load_addr] <= load_data;
  end

  assign instruction = r_instr;
  assign pc          = r_pc;
  assign busy        = (r_state == S_RUN) || (r_state == S_HOLD);
  assign done        = r_done;
  assign err         = r_err;
  assign issue_count = r_cnt;

endmodule

// File: doc/tile_instr_sequencer.md
Name: tile_instr_sequencer

Overview:
- Per-tile instruction store and issue sequencer; sits directly upstream of a CGRA tile and drives its 64-bit `instruction` input.
- A host loads up to DEPTH instructions, then starts a run. The block issues one instruction per clock, supports stall (NOP insertion), looping and a tile-clear command.
- Only this block drives the tile's `instruction` port.

Parameters:
- DEPTH, 16, instruction memory entries (power of two).
- AW, 4, address width, log2(DEPTH).
- IW, 64, instruction width.
- CW, 16, width of the issued-instruction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- load_en  input  1  write load_data into mem[load_addr]; honoured only in IDLE.
- load_addr  input  AW  write address.
- load_data  input  IW  instruction word to store.
- start  input  1  begin run; honoured only in IDLE.
- prog_len  input  AW+1  number of instructions to run, 1..DEPTH; sampled on accepted start.
- loop_en  input  1  sampled on accepted start; 1 = wrap to entry 0 after last entry.
- stop  input  1  in RUN/HOLD: finish the run at the next cycle.
- stall  input  1  tile/memory not ready; insert NOP, do not advance.
- clear_req  input  1  in IDLE: issue one tile-reset instruction.
- instruction  output  IW  registered instruction to the tile.
- pc  output  AW  index of the entry currently on `instruction` (0 when a NOP is shown).
- busy  output  1  1 in RUN or HOLD.
- done  output  1  one-cycle pulse when a run ends.
- err  output  1  one-cycle pulse when start is rejected.
- issue_count  output  CW  count of memory instructions issued since the last accepted start; saturates at all-ones.

Behaviour:
- Constants:
  - NOP = 64'h0000_0000_0000_0007 (opcode 111, reset bit 61 = 0).
  - CLR = 64'h2000_0000_0000_0007 (bit 61 set).
- Reset (rst=0, asynchronous):
  - instruction=NOP, pc=0, busy=0, done=0, err=0, issue_count=0.
  - Internal next-pointer nxt=0; state=IDLE.
  - Memory contents are not reset.
- Reset mid-run aborts immediately; no done pulse.
- States and transitions:
  - IDLE:
    - instruction=NOP each cycle.
    - load_en writes memory.
    - Priority: clear_req > start.
    - clear_req: next cycle instruction=CLR for exactly one cycle, then NOP; stay IDLE.
    - start with 1<=prog_len<=DEPTH: latch len and loop, issue_count=0, nxt=0, go RUN.
    - start with prog_len=0 or >DEPTH: err=1 next cycle, stay IDLE.
  - RUN, each cycle with stall=0:
    - instruction<=mem[nxt], pc<=nxt, issue_count+1.
    - nxt<=nxt+1, or 0 if nxt==len-1.
    - If nxt==len-1 and loop=0: go DONE after this issue.
  - RUN with stall=1: instruction<=NOP, nxt held, go HOLD.
  - HOLD:
    - stall=1: NOP again, stay.
    - stall=0: issue mem[nxt] as in RUN and return to RUN.
    - Each memory entry is issued exactly once per pass regardless of stalls.
  - DONE: instruction<=NOP, pc<=0, done=1 for this cycle, go IDLE.
- Latency: start accepted at edge T -> mem[0] on instruction after edge T+1.
- stop in RUN/HOLD: go to DONE on the next edge (instruction=NOP); the entry not yet issued is dropped.
  - stop and stall together: stop wins.
- load_en outside IDLE is ignored, with no write.
- A load to the same address in the cycle start is accepted is written before the run reads it.
- start while busy is ignored, with no err.
- prog_len=DEPTH with loop=1 wraps 15->0 with no bubble.
- issue_count holds at 16'hFFFF.

Test Plan:
- Load mem[0..2] = 64'h...0006 variants A,B,C; start prog_len=3, loop_en=0 -> instruction A,B,C on cycles T+1..T+3, pc 0,1,2; then NOP with done=1 at T+4; busy low after; issue_count=3.
- Same program, stall=1 for 2 cycles after B -> sequence A,B,NOP,NOP,C; C issued once; issue_count=3.
- loop_en=1, prog_len=2 -> A,B,A,B,...; assert stop after the 5th issue -> next cycle NOP with done=1; issue_count=5.
- start with prog_len=0, then prog_len=17 -> err pulses twice, busy stays 0, instruction stays NOP.
- clear_req in IDLE -> instruction=64'h2000_0000_0000_0007 for one cycle, then NOP; clear_req with start in the same cycle -> CLR wins, start ignored.
- rst low mid-run at issue 2 of 3 -> outputs immediately NOP/0 with no done pulse; after release a new start runs from mem[0] and memory is retained.
